// File: rtl/csa_pkg.sv
// Shared FSM state codes and width/row-count helpers for the carry-save stream accumulator.
package csa_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  function automatic int unsigned acc_w(input int unsigned out_w, input int unsigned guard_w);
    return out_w + guard_w;
  endfunction

  // Each 3:2 row turns three operands into two, so n operands need n-2 rows.
  function automatic int unsigned csa_levels(input int unsigned n_operands);
    return (n_operands > 2) ? n_operands - 2 : 0;
  endfunction

endpackage

// File: rtl/csa_stream_accum_csa_3to2_row.sv
// One row of 3:2 carry-save compression; the carry output is already weighted (shifted left).
module csa_3to2_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_stream_accum.sv
// Streaming N-lane carry-save accumulator with a single resolve add per vector.
// Optional macro CSA_SAT_EN clamps out_data to all ones when guard bits are set.
module csa_stream_accum
  import csa_pkg::*;
#(
  parameter int unsigned IN_W      = 21,
  parameter int unsigned LANES     = 3,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned GUARD_W   = 4,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*IN_W-1:0]            in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 out_data,
  output logic                             out_ovf,
  output logic [$clog2(MAX_BEATS+1)-1:0]   out_beats
);

  localparam int unsigned ACC_W = acc_w(OUT_W, GUARD_W);
  localparam int unsigned NROWS = csa_levels(LANES + 2);
  localparam int unsigned BW    = $clog2(MAX_BEATS + 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, carry_q;
  logic [BW-1:0]    beats_q;
  logic             ovf_q;
  logic             accept_c;
  logic [OUT_W-1:0] res_c;

  logic [ACC_W-1:0] lane      [LANES];
  logic [ACC_W-1:0] s_chain   [NROWS+1];
  logic [ACC_W-1:0] c_chain   [NROWS+1];

  assign accept_c = in_valid & in_ready;

  // Running sum/carry pair enters the chain; each row folds in one more lane.
  assign s_chain[0] = sum_q;
  assign c_chain[0] = carry_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane[k] = ACC_W'(in_data[k*IN_W +: IN_W]);
  end

  for (genvar i = 0; i < NROWS; i++) begin : g_row
    csa_3to2_row #(.W(ACC_W)) u_row (
      .a     (s_chain[i]),
      .b     (c_chain[i]),
      .c     (lane[i]),
      .sum   (s_chain[i+1]),
      .carry (c_chain[i+1])
    );
  end

`ifdef CSA_SAT_EN
  logic [ACC_W-1:0] resolved_c;
  assign resolved_c = sum_q + carry_q;
  assign res_c = (|resolved_c[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : resolved_c[OUT_W-1:0];
`else
  assign res_c = OUT_W'(sum_q + carry_q);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: if (accept_c) state_d = in_last ? S_RESOLVE : S_ACCUM;
      S_RESOLVE:       state_d = S_OUTPUT;
      S_OUTPUT:        if (out_ready) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == S_IDLE) || (state_d == S_ACCUM);
      out_valid <= (state_d == S_OUTPUT);
    end
  end

  // Carry-save state, beat counting and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      beats_q   <= '0;
      ovf_q     <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else if (accept_c) begin
      sum_q   <= s_chain[NROWS];
      carry_q <= c_chain[NROWS];
      if (beats_q == BW'(MAX_BEATS)) ovf_q   <= 1'b1;
      else                           beats_q <= beats_q + 1'b1;
    end else if (state_q == S_RESOLVE) begin
      out_data  <= res_c;
      out_ovf   <= ovf_q;
      out_beats <= beats_q;
    end else if ((state_q == S_OUTPUT) && out_ready) begin
      sum_q   <= '0;
      carry_q <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_stream_accum.sv
// Bench for csa_stream_accum: reference model of vector sums plus directed literal results.
module tb_csa_stream_accum;

  localparam int unsigned IN_W      = 21;
  localparam int unsigned LANES     = 3;
  localparam int unsigned OUT_W     = 32;
  localparam int unsigned GUARD_W   = 4;
  localparam int unsigned MAX_BEATS = 256;
  localparam int unsigned ACC_W     = OUT_W + GUARD_W;
  localparam int unsigned BW        = $clog2(MAX_BEATS + 1);
  localparam int unsigned LW        = LANES * IN_W;
  localparam logic [20:0] LMAX      = 21'h1F_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LW-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic [BW-1:0]    out_beats;

  int checks = 0;
  int failures = 0;

  csa_stream_accum #(
    .IN_W(IN_W), .LANES(LANES), .OUT_W(OUT_W), .GUARD_W(GUARD_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: 0 = accepting beats, 1 = resolving, 2 = presenting result.
  int          phase = 0;
  logic [63:0] acc = '0;
  int          mbeats = 0;
  bit          movf = 0;
  logic [63:0] exp_data = '0;
  int          exp_beats = 0;
  bit          exp_ovf = 0;
  int          cap_cnt = 0;
  logic [63:0] cap_data = '0;
  int          cap_beats = 0;
  bit          cap_ovf = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_out_beats", 64'(out_beats), 64'd0);
      phase = 0; acc = '0; mbeats = 0; movf = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(phase == 0));
      chk("out_valid", 64'(out_valid), 64'(phase == 2));
      if (phase == 2) begin
        chk("out_data", 64'(out_data), exp_data);
        chk("out_ovf", 64'(out_ovf), 64'(exp_ovf));
        chk("out_beats", 64'(out_beats), 64'(exp_beats));
        if (out_ready) begin
          cap_data = 64'(out_data); cap_beats = int'(out_beats); cap_ovf = out_ovf;
          cap_cnt++;
        end
      end
      if (phase == 0 && in_valid) begin
        for (int k = 0; k < int'(LANES); k++) acc = acc + 64'(in_data[k*IN_W +: IN_W]);
        acc = acc & ((64'd1 << ACC_W) - 64'd1);
        if (mbeats == int'(MAX_BEATS)) movf = 1;
        else mbeats++;
        if (in_last) begin
`ifdef CSA_SAT_EN
          exp_data = ((acc >> OUT_W) != 0) ? ((64'd1 << OUT_W) - 64'd1) : acc;
`else
          exp_data = acc & ((64'd1 << OUT_W) - 64'd1);
`endif
          exp_beats = mbeats; exp_ovf = movf;
          phase = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && out_ready) begin
        phase = 0; acc = '0; mbeats = 0; movf = 0;
      end
    end
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom % 3) != 0;
  end

  task automatic send_beat(input logic [20:0] l0, input logic [20:0] l1,
                           input logic [20:0] l2, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = {l2, l1, l0};
    in_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 3000);
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready stayed 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    int start = cap_cnt;
    while (cap_cnt == start && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL out_timeout no result handshake seen, required 1");
    end
    @(posedge clk); #1;
  endtask

  int c0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat vector.
    send_beat(21'd5, 21'd7, 21'd9, 1'b1);
    wait_out();
    chk("t1_data", cap_data, 64'd21);
    chk("t1_beats", 64'(cap_beats), 64'd1);
    chk("t1_ovf", 64'(cap_ovf), 64'd0);

    // Four back-to-back full-scale beats.
    for (int i = 0; i < 4; i++) send_beat(LMAX, LMAX, LMAX, i == 3);
    wait_out();
    chk("t2_data", cap_data, 64'd25165812);
    chk("t2_beats", 64'(cap_beats), 64'd4);

    // Consumer stalls; input pulses during OUTPUT must be ignored.
    out_ready = 1'b0;
    send_beat(21'd10, 21'd20, 21'd30, 1'b1);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'($urandom % 2);
      in_data  = LW'({$urandom, $urandom});
      in_last  = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    wait_out();
    chk("t3_data", cap_data, 64'd60);
    send_beat(21'd1, 21'd2, 21'd3, 1'b1);
    wait_out();
    chk("t3_next_data", cap_data, 64'd6);

    // Counter saturation and sticky overflow.
    for (int i = 0; i < 258; i++) send_beat(21'd1, 21'd1, 21'd1, i == 257);
    wait_out();
    chk("t4_beats", 64'(cap_beats), 64'd256);
    chk("t4_ovf", 64'(cap_ovf), 64'd1);
    chk("t4_data", cap_data, 64'd774);

    // Sum beyond OUT_W: wrap or clamp.
    for (int i = 0; i < 700; i++) send_beat(LMAX, LMAX, LMAX, i == 699);
    wait_out();
`ifdef CSA_SAT_EN
    chk("t5_data_sat", cap_data, 64'd4294967295);
`else
    chk("t5_data_wrap", cap_data, 64'd109049804);
`endif
    chk("t5_ovf", 64'(cap_ovf), 64'd1);

    // Reset in the middle of a vector.
    send_beat(21'd100, 21'd200, 21'd300, 1'b0);
    send_beat(21'd400, 21'd500, 21'd600, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    c0 = cap_cnt;
    send_beat(21'd1, 21'd2, 21'd3, 1'b1);
    wait_out();
    chk("t6_data", cap_data, 64'd6);
    chk("t6_results", 64'(cap_cnt - c0), 64'd1);

    // Random vectors, gaps and back-pressure.
    rand_ready = 1;
    for (int v = 0; v < 25; v++) begin
      int nb;
      nb = int'($urandom_range(1, 8));
      for (int b = 0; b < nb; b++) begin
        if ($urandom % 4 == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_beat(21'($urandom), 21'($urandom), 21'($urandom), b == nb - 1);
      end
      wait_out();
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
